program_loader: RTL and testbench

- Sequences the shared 8-bit bus, the MAR and the 16-byte RAM to write a program image from the chip input pins into RAM before the CPU runs.
- Holds the CPU (control_block and program counter) in reset while loading, then releases it.
- Sits beside control_block at the top level. It drives the bus only while loading and tri-states it at all other times.

---
 rtl/program_loader.sv | 162 ++++++++++++++++
 tb/tb_program_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: copies a RAM_BYTES-long image from the input pins into RAM
// over the shared 8-bit bus (MAR address, MAR data, RAM write), holding the CPU
// in reset while it does so. All outputs are registered and depend only on state.
module program_loader #(
    parameter int unsigned RAM_BYTES = 16,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              run,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    output logic              n_load_addr,
    output logic              n_load_data,
    output logic              n_write,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] load_addr,
    output logic              done
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitByte,
        StDriveAddr,
        StDriveData,
        StWrite,
        StDone
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(RAM_BYTES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    logic              in_ready_d;
    logic [7:0]        bus_out_d;
    logic              bus_oe_d;
    logic              n_load_addr_d;
    logic              n_load_data_d;
    logic              n_write_d;
    logic              cpu_hold_d;
    logic              done_d;

    // Next-state, address counter and holding register.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                // start wins over run
                if (start) begin
                    state_d = StWaitByte;
                    addr_d  = '0;
                end else if (run) begin
                    state_d = StDone;
                end
            end
            StWaitByte: begin
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = StDriveAddr;
                end
            end
            StDriveAddr: state_d = StDriveData;
            StDriveData: state_d = StWrite;
            StWrite: begin
                if (addr_q == LastAddr) begin
                    state_d = StDone;
                    addr_d  = '0;
                end else begin
                    state_d = StWaitByte;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            StDone: begin
                // Reload; run is ignored here
                if (start) begin
                    state_d = StWaitByte;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                addr_d  = '0;
            end
        endcase
    end

    // Decode the outputs for the upcoming state so they can be registered.
    always_comb begin
        in_ready_d    = 1'b0;
        bus_out_d     = 8'h00;
        bus_oe_d      = 1'b0;
        n_load_addr_d = 1'b1;
        n_load_data_d = 1'b1;
        n_write_d     = 1'b1;
        cpu_hold_d    = 1'b1;
        done_d        = 1'b0;
        unique case (state_d)
            StIdle: ;
            StWaitByte: in_ready_d = 1'b1;
            StDriveAddr: begin
                bus_oe_d      = 1'b1;
                bus_out_d     = 8'(addr_d);
                n_load_addr_d = 1'b0;
            end
            StDriveData: begin
                bus_oe_d      = 1'b1;
                bus_out_d     = data_d;
                n_load_data_d = 1'b0;
            end
            StWrite: begin
                bus_oe_d  = 1'b1;
                bus_out_d = data_d;
                n_write_d = 1'b0;
            end
            StDone: begin
                cpu_hold_d = 1'b0;
                done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            data_q      <= 8'h00;
            in_ready    <= 1'b0;
            bus_out     <= 8'h00;
            bus_oe      <= 1'b0;
            n_load_addr <= 1'b1;
            n_load_data <= 1'b1;
            n_write     <= 1'b1;
            cpu_hold    <= 1'b1;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            in_ready    <= in_ready_d;
            bus_out     <= bus_out_d;
            bus_oe      <= bus_oe_d;
            n_load_addr <= n_load_addr_d;
            n_load_data <= n_load_data_d;
            n_write     <= n_write_d;
            cpu_hold    <= cpu_hold_d;
            done        <= done_d;
        end
    end

    assign load_addr = addr_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random images and handshake gaps, with a model of
// the MAR/RAM on the bus and an expected bus-event trace built from the image.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, run;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       n_load_addr, n_load_data, n_write;
    logic       cpu_hold;
    logic [3:0] load_addr;
    logic       done;

    program_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .run         (run),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .n_load_addr (n_load_addr),
        .n_load_data (n_load_data),
        .n_write     (n_write),
        .cpu_hold    (cpu_hold),
        .load_addr   (load_addr),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int bad_inv = 0;

    // Stimulus settings for one load
    logic [7:0] img[16];
    int         gap[16];
    int         sw_byte;
    int         abort_byte;
    logic       start_with_run;

    // Bus-side model: MAR, data latch, RAM, and the observed strobe trace
    logic [3:0] mar;
    logic [7:0] mdr;
    logic [7:0] ram[16];
    logic [7:0] exp_ram[16];
    logic [9:0] obs[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Watch the bus each cycle: record strobes, update MAR/RAM, flag rule breaks.
    always @(negedge clk) begin : monitor
        int lows;
        if (rst_n === 1'b1) begin
            lows = 0;
            if (n_load_addr === 1'b0) begin
                lows++;
                obs.push_back({2'd0, bus_out});
                mar = bus_out[3:0];
            end
            if (n_load_data === 1'b0) begin
                lows++;
                obs.push_back({2'd1, bus_out});
                mdr = bus_out;
            end
            if (n_write === 1'b0) begin
                lows++;
                obs.push_back({2'd2, bus_out});
                ram[mar] = mdr;
            end
            if (lows > 1) bad_inv++;
            if (lows > 0 && bus_oe !== 1'b1) bad_inv++;
            if (bus_oe === 1'b1 && cpu_hold !== 1'b1) bad_inv++;
            if (done === 1'b1 && cpu_hold !== 1'b0) bad_inv++;
        end
    end

    task automatic check_reset_vals(input string tag);
        check_eq(tag, {cpu_hold, bus_oe, bus_out, n_load_addr, n_load_data, n_write,
                       in_ready, done, load_addr},
                 {1'b1, 1'b0, 8'h00, 3'b111, 1'b0, 1'b0, 4'h0});
    endtask

    task automatic check_trace(input int n);
        logic [9:0] e;
        check_eq("trace_len", obs.size(), n);
        for (int j = 0; j < n && j < obs.size(); j++) begin
            if (j % 3 == 0) e = {2'd0, 8'(j / 3)};
            else            e = {2'(j % 3), img[j / 3]};
            check_eq($sformatf("trace[%0d]", j), obs[j], e);
        end
    endtask

    task automatic check_ram(input string tag);
        for (int j = 0; j < 16; j++) check_eq($sformatf("%s[%0d]", tag, j), ram[j], exp_ram[j]);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Run one load from IDLE or DONE. Called at a slot #1 after a clock edge.
    task automatic do_load();
        int c0;
        int gsum;
        logic ok;
        gsum = 0;
        for (int j = 0; j < 16; j++) gsum += gap[j];
        obs.delete();
        in_valid = 1'b0;
        start    = 1'b1;
        run      = start_with_run;
        @(posedge clk);
        #1;
        start = 1'b0;
        run   = 1'b0;
        c0    = cyc;
        check_eq("start", {in_ready, cpu_hold, done, load_addr}, {1'b1, 1'b1, 1'b0, 4'h0});
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("ready[%0d]", i), in_ready, 1'b1);
            if (in_ready !== 1'b1) return;
            for (int g = 0; g < gap[i]; g++) begin
                @(posedge clk);
                #1;
                check_eq("bp_wait", {in_ready, bus_oe, n_load_addr, n_load_data, n_write,
                                     load_addr}, {1'b1, 1'b0, 3'b111, 4'(i)});
            end
            in_valid = 1'b1;
            in_data  = img[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            if (i == abort_byte) begin
                @(posedge clk);
                #1;
                check_eq("abort_in_data", n_load_data, 1'b0);
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_vals("reset_mid_load");
                return;
            end
            ok = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk);
                #1;
                if (start) begin
                    start = 1'b0;
                    if (i < 15) check_eq("start_in_write_ignored", load_addr, 4'(i + 1));
                end
                if (in_ready || done) begin
                    ok = 1'b1;
                    break;
                end
                if (i == sw_byte && n_write === 1'b0) start = 1'b1;
            end
            check_eq($sformatf("next_byte_wait[%0d]", i), ok, 1'b1);
            if (!ok) return;
        end
        check_eq("done", {done, cpu_hold, in_ready, bus_oe}, 4'b1000);
        check_eq("load_cycles", cyc - c0, 64 + gsum);
    endtask

    task automatic new_image(input logic rnd_gaps);
        for (int j = 0; j < 16; j++) begin
            img[j] = 8'($urandom);
            gap[j] = (rnd_gaps && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
        end
        sw_byte        = -1;
        abort_byte     = -1;
        start_with_run = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; run = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        mar = 4'h0; mdr = 8'h00;
        for (int j = 0; j < 16; j++) begin
            ram[j]     = 8'h00;
            exp_ram[j] = 8'h00;
        end

        // Asynchronous reset, asserted between edges
        #3 rst_n = 1'b0;
        #1 check_reset_vals("reset_async");
        release_reset();
        check_eq("idle", {cpu_hold, done, in_ready, bus_oe}, 4'b1000);

        // Run bypass: straight to DONE, no bus activity; run ignored afterwards
        obs.delete();
        run = 1'b1;
        @(posedge clk);
        #1;
        run = 1'b0;
        check_eq("bypass", {done, cpu_hold, bus_oe, in_ready}, 4'b1000);
        run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run = 1'b0;
        check_eq("run_in_done", {done, cpu_hold, in_ready}, 3'b100);
        check_eq("bypass_strobes", obs.size(), 0);
        rst_n = 1'b0;
        release_reset();

        // Full load of 0x10..0x1F, start and run together
        new_image(1'b0);
        for (int j = 0; j < 16; j++) img[j] = 8'h10 + 8'(j);
        start_with_run = 1'b1;
        do_load();
        check_trace(48);
        for (int j = 0; j < 16; j++) exp_ram[j] = img[j];
        check_ram("ram_full");

        // Reload from DONE with 5 idle cycles before byte 3
        new_image(1'b0);
        gap[3] = 5;
        do_load();
        check_trace(48);
        for (int j = 0; j < 16; j++) exp_ram[j] = img[j];
        check_ram("ram_bp");

        // Random gaps, start pulsed during one WRITE
        new_image(1'b1);
        sw_byte = $urandom_range(0, 15);
        do_load();
        check_trace(48);
        for (int j = 0; j < 16; j++) exp_ram[j] = img[j];
        check_ram("ram_rand");

        // Reset during DRIVE_DATA of byte 7: bytes 0..6 land, the rest stays old
        new_image(1'b0);
        abort_byte = 7;
        do_load();
        check_trace(22);
        for (int j = 0; j < 7; j++) exp_ram[j] = img[j];
        check_ram("ram_abort");
        release_reset();
        check_eq("idle_after_abort", {cpu_hold, done, in_ready, load_addr},
                 {1'b1, 1'b0, 1'b0, 4'h0});

        // Fresh random load from IDLE
        new_image(1'b1);
        do_load();
        check_trace(48);
        for (int j = 0; j < 16; j++) exp_ram[j] = img[j];
        check_ram("ram_final");

        check_eq("invariants", bad_inv, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
